// File: rtl/sl12_arb.sv
// Root 2:1 arbiter of the same-latency tree: merges two masters onto one request port with
// independent round-robin read/write arbitration and steers read responses back by tag.
//
// Request vector (66 bits):  [65] ren, [64:49] raddr, [48] wen, [47:32] waddr, [31:0] wdata
// Response vector (33 bits): [32] rvalid, [31:0] rdata
module sl12_arb #(
  parameter int RD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [65:0] req_m0,
  output logic        rrdy_m0,
  output logic        wrdy_m0,
  output logic [32:0] res_m0,
  input  logic [65:0] req_m1,
  output logic        rrdy_m1,
  output logic        wrdy_m1,
  output logic [32:0] res_m1,
  output logic [65:0] req_down,
  input  logic [32:0] res_down,
  output logic        rsp_err
);

  localparam int REQ_W  = 66;
  localparam int WREQ_W = 49;
  localparam int RREQ_W = REQ_W - WREQ_W;

  logic ren0, ren1, wen0, wen1;
  logic rd_fav, wr_fav;                 // 0 favours m0, 1 favours m1
  logic [RREQ_W-1:0] rreq_sel;
  logic [WREQ_W-1:0] wreq_sel;
  logic [RD_LAT:0] tag_vld;
  logic [RD_LAT:0] tag_id;
  logic tail_vld, tail_id, rvalid;

  assign ren0 = req_m0[REQ_W-1];
  assign ren1 = req_m1[REQ_W-1];
  assign wen0 = req_m0[WREQ_W-1];
  assign wen1 = req_m1[WREQ_W-1];

  assign rrdy_m0 = ren0 & (~ren1 | ~rd_fav);
  assign rrdy_m1 = ren1 & ~rrdy_m0;
  assign wrdy_m0 = wen0 & (~wen1 | ~wr_fav);
  assign wrdy_m1 = wen1 & ~wrdy_m0;

  always_comb begin
    rreq_sel = '0;
    wreq_sel = '0;
    if (rrdy_m0)      rreq_sel = req_m0[REQ_W-1:WREQ_W];
    else if (rrdy_m1) rreq_sel = req_m1[REQ_W-1:WREQ_W];
    if (wrdy_m0)      wreq_sel = req_m0[WREQ_W-1:0];
    else if (wrdy_m1) wreq_sel = req_m1[WREQ_W-1:0];
  end

  assign tail_vld = tag_vld[RD_LAT];
  assign tail_id  = tag_id[RD_LAT];
  assign rvalid   = res_down[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_down <= '0;
      res_m0   <= '0;
      res_m1   <= '0;
      rsp_err  <= 1'b0;
      rd_fav   <= 1'b0;
      wr_fav   <= 1'b0;
      tag_vld  <= '0;
      tag_id   <= '0;
    end else begin
      req_down <= {rreq_sel, wreq_sel};
      // After any grant the pointer favours the master that was not granted.
      if (rrdy_m0 | rrdy_m1) rd_fav <= rrdy_m0;
      if (wrdy_m0 | wrdy_m1) wr_fav <= wrdy_m0;
      tag_vld <= {tag_vld[RD_LAT-1:0], rrdy_m0 | rrdy_m1};
      tag_id  <= {tag_id[RD_LAT-1:0], rrdy_m1};
      res_m0  <= (rvalid & tail_vld & ~tail_id) ? res_down : '0;
      res_m1  <= (rvalid & tail_vld &  tail_id) ? res_down : '0;
      // A response without a tag, or a tag without a response, both mean the tree lost sync.
      rsp_err <= rsp_err | (rvalid ^ tail_vld);
    end
  end

endmodule

// File: tb/tb_sl12_arb.sv
// Bench for sl12_arb: directed scenarios plus randomized traffic, checked against a
// cycle-indexed model of grants, tree responses and expected steering.
module tb_sl12_arb;
  localparam int RD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [65:0] req_m0, req_m1, req_down;
  logic        rrdy_m0, wrdy_m0, rrdy_m1, wrdy_m1, rsp_err;
  logic [32:0] res_m0, res_m1, res_down;

  always #5 clk = ~clk;

  sl12_arb #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_m0(req_m0), .rrdy_m0(rrdy_m0), .wrdy_m0(wrdy_m0), .res_m0(res_m0),
    .req_m1(req_m1), .rrdy_m1(rrdy_m1), .wrdy_m1(wrdy_m1), .res_m1(res_m1),
    .req_down(req_down), .res_down(res_down), .rsp_err(rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  bit          rd_fav, wr_fav, exp_err;
  logic [65:0] exp_req;
  logic [32:0] exp_res0, exp_res1;
  bit          tree_v [64];
  logic [31:0] tree_d [64];
  bit          tag_v  [64];
  bit          tag_id [64];
  bit          g_r0, g_r1, g_w0, g_w1;
  logic        cap_rrdy1, cap_wrdy0;

  function automatic logic [16:0] mk_r(input logic [15:0] a);
    return {1'b1, a};
  endfunction

  function automatic logic [48:0] mk_w(input logic [15:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called just after a falling edge with inputs already applied; returns after the next falling edge.
  task automatic step();
    int s, slot;
    logic r0, r1, w0, w1;
    logic [16:0] rq;
    logic [48:0] wq;
    s = cyc % 64;
    res_down = tree_v[s] ? {1'b1, tree_d[s]} : 33'd0;
    #1;
    r0 = req_m0[65]; r1 = req_m1[65];
    w0 = req_m0[48]; w1 = req_m1[48];
    g_r0 = r0 && (!r1 || !rd_fav);
    g_r1 = r1 && !g_r0;
    g_w0 = w0 && (!w1 || !wr_fav);
    g_w1 = w1 && !g_w0;
    cap_rrdy1 = rrdy_m1;
    cap_wrdy0 = wrdy_m0;
    chk("rrdy_m0", rrdy_m0, g_r0);
    chk("rrdy_m1", rrdy_m1, g_r1);
    chk("wrdy_m0", wrdy_m0, g_w0);
    chk("wrdy_m1", wrdy_m1, g_w1);
    rq = g_r0 ? req_m0[65:49] : (g_r1 ? req_m1[65:49] : 17'd0);
    wq = g_w0 ? req_m0[48:0]  : (g_w1 ? req_m1[48:0]  : 49'd0);
    exp_req = {rq, wq};
    if (g_r0 || g_r1) begin
      rd_fav = g_r0;
      slot = (cyc + 1 + RD_LAT) % 64;
      tree_v[slot] = 1'b1;
      tree_d[slot] = $urandom;
      tag_v[slot]  = 1'b1;
      tag_id[slot] = g_r1;
    end
    if (g_w0 || g_w1) wr_fav = g_w0;
    exp_res0 = (tree_v[s] && tag_v[s] && !tag_id[s]) ? {1'b1, tree_d[s]} : 33'd0;
    exp_res1 = (tree_v[s] && tag_v[s] &&  tag_id[s]) ? {1'b1, tree_d[s]} : 33'd0;
    if (tree_v[s] != tag_v[s]) exp_err = 1'b1;
    tree_v[s] = 1'b0;
    tag_v[s]  = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("req_down", req_down, exp_req);
    chk("res_m0", res_m0, exp_res0);
    chk("res_m1", res_m1, exp_res1);
    chk("rsp_err", rsp_err, exp_err);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_m0 = '0;
    req_m1 = '0;
    repeat (n) step();
  endtask

  initial begin
    int t0;
    logic [16:0] p0r, p1r;
    logic [48:0] p0w, p1w;
    logic [31:0] wd;

    rst_n = 1'b0;
    req_m0 = '0; req_m1 = '0; res_down = '0;
    exp_req = '0; exp_res0 = '0; exp_res1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_down", req_down, 66'd0);
    chk("rst_res_m0", res_m0, 66'd0);
    chk("rst_res_m1", res_m1, 66'd0);
    chk("rst_rsp_err", rsp_err, 66'd0);
    rst_n = 1'b1;

    idle(10);
    chk("idle_req_down", req_down, 66'd0);
    chk("idle_rsp_err", rsp_err, 66'd0);

    // lone m0 read, response expected six cycles after the grant
    t0 = cyc;
    req_m0 = {mk_r(16'h0010), 49'd0};
    step();
    chk("dir_rreq", req_down[65:49], 66'h10010);
    idle(5);
    chk("dir_rsp_cycle", cyc, t0 + 6);
    chk("dir_res_m0_vld", res_m0[32], 66'd1);
    chk("dir_res_m1_zero", res_m1, 66'd0);

    // lone m1 read returns the pointer to favour m0
    req_m1 = {mk_r(16'h0011), 49'd0};
    step();
    req_m1 = '0;

    // both masters keep reading: grants must alternate starting with m0
    req_m0 = {mk_r(16'h0100), 49'd0};
    req_m1 = {mk_r(16'h0200), 49'd0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_grant", cap_rrdy1, (i % 2 == 1) ? 66'd1 : 66'd0);
      if (g_r0) req_m0 = {mk_r(16'h0101 + 16'(i)), 49'd0};
      if (g_r1) req_m1 = {mk_r(16'h0201 + 16'(i)), 49'd0};
    end
    idle(RD_LAT + 3);

    // write from m0 and read from m1 in the same cycle
    wd = 32'hcafe_0020;
    req_m0 = {17'd0, mk_w(16'h0020, wd)};
    req_m1 = {mk_r(16'h0030), 49'd0};
    step();
    chk("mix_wrdy0", cap_wrdy0, 66'd1);
    chk("mix_rrdy1", cap_rrdy1, 66'd1);
    chk("mix_req_down", req_down, {mk_r(16'h0030), mk_w(16'h0020, wd)});
    idle(RD_LAT + 3);

    // randomized traffic: masters hold each request until granted
    p0r = '0; p1r = '0; p0w = '0; p1w = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0r[16] && $urandom_range(0, 1) == 1) p0r = mk_r(16'($urandom_range(0, 65535)));
      if (!p1r[16] && $urandom_range(0, 1) == 1) p1r = mk_r(16'($urandom_range(0, 65535)));
      if (!p0w[48] && $urandom_range(0, 2) == 0) p0w = mk_w(16'($urandom_range(0, 65535)), $urandom);
      if (!p1w[48] && $urandom_range(0, 2) == 0) p1w = mk_w(16'($urandom_range(0, 65535)), $urandom);
      req_m0 = {p0r, p0w};
      req_m1 = {p1r, p1w};
      step();
      if (g_r0) p0r = '0;
      if (g_r1) p1r = '0;
      if (g_w0) p0w = '0;
      if (g_w1) p1w = '0;
    end
    idle(RD_LAT + 4);
    chk("rand_no_err", rsp_err, 66'd0);

    // unsolicited response
    tree_v[cyc % 64] = 1'b1;
    tree_d[cyc % 64] = 32'hdead_beef;
    idle(1);
    chk("inj_err_set", rsp_err, 66'd1);
    chk("inj_dropped_m0", res_m0, 66'd0);
    idle(5);
    chk("inj_err_sticky", rsp_err, 66'd1);

    // reset with two reads in flight
    req_m0 = {mk_r(16'h0040), 49'd0};
    step();
    req_m0 = '0;
    req_m1 = {mk_r(16'h0050), 49'd0};
    step();
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_down", req_down, 66'd0);
    chk("mid_rst_res_m0", res_m0, 66'd0);
    chk("mid_rst_res_m1", res_m1, 66'd0);
    chk("mid_rst_rsp_err", rsp_err, 66'd0);
    for (int i = 0; i < 64; i++) tag_v[i] = 1'b0;
    rd_fav = 1'b0; wr_fav = 1'b0; exp_err = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(RD_LAT + 4);
    chk("late_rsp_err", rsp_err, 66'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
